// File: rtl/line_matrix_pkg.sv
// Shared encodings for the line_router crossbar: output conditioning modes and
// source-select codes (two constants followed by the synchronised input lines).
package line_matrix_pkg;

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_RISE   = 2'd2;
  localparam logic [1:0] MODE_FALL   = 2'd3;

  localparam int SRC_CONST0 = 0;
  localparam int SRC_CONST1 = 1;
  localparam int SRC_BASE   = 2;

endpackage

// File: rtl/line_cond.sv
// One routed output channel: config entry, glitch filter, edge history and the
// registered output in level / invert / rise-pulse / fall-pulse mode.
module line_cond
  import line_matrix_pkg::*;
#(
  parameter int SRC_W  = 4,
  parameter int FILT_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr,
  input  logic [SRC_W-1:0]  wr_src,
  input  logic [1:0]        wr_mode,
  input  logic [FILT_W-1:0] wr_filt,
  input  logic              raw,
  output logic [SRC_W-1:0]  src,
  output logic [1:0]        mode,
  output logic [FILT_W-1:0] filt,
  output logic              line
);

  logic              lvl;
  logic              prev;
  logic              line_d;
  logic [FILT_W-1:0] cnt;

  // NOTE: the config entry is a handful of flops rather than a RAM, so it is
  // safe and intended to clear it on the async reset along with the datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src  <= '0;
      mode <= MODE_LEVEL;
      filt <= '0;
    end else if (wr) begin
      src  <= wr_src;
      mode <= wr_mode;
      filt <= wr_filt;
    end
  end

  // The counter only ever reaches filt before being cleared, so it cannot wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl  <= 1'b0;
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= lvl;
      if (raw == lvl) begin
        cnt <= '0;
      end else if (cnt == filt) begin
        lvl <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + FILT_W'(1);
      end
      if (wr) cnt <= '0;
    end
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred even if a mode is added later without a matching arm.
    line_d = lvl;
    case (mode)
      MODE_INVERT: line_d = ~lvl;
      MODE_RISE:   line_d = lvl & ~prev;
      MODE_FALL:   line_d = ~lvl & prev;
      default:     line_d = lvl;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) line <= 1'b0;
    else       line <= line_d;
  end

endmodule

// File: rtl/line_router.sv
// NUM_INPUTS x NUM_OUTPUTS line crossbar: input synchronisers, per-output source
// muxes feeding line_cond channels, and a combinational config readback port.
module line_router
  import line_matrix_pkg::*;
#(
  parameter  int NUM_INPUTS  = 10,
  parameter  int NUM_OUTPUTS = 10,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILT_W      = 8,
  localparam int OUT_W       = $clog2(NUM_OUTPUTS),
  localparam int SRC_W       = $clog2(NUM_INPUTS + 2)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_INPUTS-1:0]  input_lines,
  input  logic                   cfg_wr,
  input  logic [OUT_W-1:0]       cfg_out,
  input  logic [SRC_W-1:0]       cfg_src,
  input  logic [1:0]             cfg_mode,
  input  logic [FILT_W-1:0]      cfg_filt,
  input  logic [OUT_W-1:0]       rd_sel,
  output logic [SRC_W-1:0]       rd_src,
  output logic [1:0]             rd_mode,
  output logic [FILT_W-1:0]      rd_filt,
  output logic [NUM_OUTPUTS-1:0] output_lines
);

  localparam int NUM_SRC = NUM_INPUTS + 2;

  logic [NUM_INPUTS-1:0] synced;
  logic [NUM_SRC-1:0]    src_vec;
  logic [SRC_W-1:0]      wr_src;
  logic [SRC_W-1:0]      src  [NUM_OUTPUTS];
  logic [1:0]            mode [NUM_OUTPUTS];
  logic [FILT_W-1:0]     filt [NUM_OUTPUTS];

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign synced = input_lines;
    end else begin : g_sync
      logic [NUM_INPUTS-1:0] stage [SYNC_STAGES];
      // NOTE: non-blocking assignments make every stage sample its predecessor's
      // old value, so the chain shifts exactly one stage per clock.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= input_lines;
          for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
      end
      assign synced = stage[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    src_vec                         = '0;
    src_vec[SRC_CONST1]             = 1'b1;
    src_vec[SRC_BASE +: NUM_INPUTS] = synced;
  end

  // Unknown source codes are stored as const0 so the entry reads back what it drives.
  assign wr_src = ({1'b0, cfg_src} < (SRC_W + 1)'(NUM_SRC)) ? cfg_src : SRC_W'(SRC_CONST0);

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_chan
    line_cond #(
      .SRC_W (SRC_W),
      .FILT_W(FILT_W)
    ) u_cond (
      .clk    (clk),
      .rstn   (rstn),
      .wr     (cfg_wr && (cfg_out == OUT_W'(j))),
      .wr_src (wr_src),
      .wr_mode(cfg_mode),
      .wr_filt(cfg_filt),
      .raw    (src_vec[src[j]]),
      .src    (src[j]),
      .mode   (mode[j]),
      .filt   (filt[j]),
      .line   (output_lines[j])
    );
  end

  always_comb begin
    rd_src  = '0;
    rd_mode = '0;
    rd_filt = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (rd_sel == OUT_W'(j)) begin
        rd_src  = src[j];
        rd_mode = mode[j];
        rd_filt = filt[j];
      end
    end
  end

endmodule

// File: tb/tb_line_router.sv
// Self-checking bench for line_router: directed latency/filter/pulse/reset
// sequences, a config readback table, and a randomized run against a window model.
module tb_line_router;

  localparam int NI   = 10;
  localparam int NO   = 10;
  localparam int SYNC = 2;
  localparam int FW   = 8;
  localparam int OW   = $clog2(NO);
  localparam int SW   = $clog2(NI + 2);
  localparam int NCYC = 2000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NI-1:0] input_lines = '0;
  logic          cfg_wr = 1'b0;
  logic [OW-1:0] cfg_out = '0;
  logic [SW-1:0] cfg_src = '0;
  logic [1:0]    cfg_mode = '0;
  logic [FW-1:0] cfg_filt = '0;
  logic [OW-1:0] rd_sel = '0;
  logic [SW-1:0] rd_src;
  logic [1:0]    rd_mode;
  logic [FW-1:0] rd_filt;
  logic [NO-1:0] output_lines;

  always #5 clk = ~clk;

  line_router #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .SYNC_STAGES(SYNC),
    .FILT_W     (FW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .input_lines (input_lines),
    .cfg_wr      (cfg_wr),
    .cfg_out     (cfg_out),
    .cfg_src     (cfg_src),
    .cfg_mode    (cfg_mode),
    .cfg_filt    (cfg_filt),
    .rd_sel      (rd_sel),
    .rd_src      (rd_src),
    .rd_mode     (rd_mode),
    .rd_filt     (rd_filt),
    .output_lines(output_lines)
  );

  typedef struct {
    int         out;
    int         src;
    int         mode;
    int         filt;
    int         sel;
    int         exp_src;
    int         exp_mode;
    int         exp_filt;
    logic [9:0] exp_lines;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: configured entries plus per-cycle histories of the
  // sampled inputs, each output's raw line and its filtered level.
  int          m_src [NO];
  int          m_mode[NO];
  int          m_filt[NO];
  int          m_last_wr[NO];
  bit [NI-1:0] in_hist [NCYC+1];
  bit          raw_hist[NO][NCYC+1];
  bit          lvl_hist[NO][NCYC+1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int j = 0; j < NO; j++) begin
      m_src[j] = 0; m_mode[j] = 0; m_filt[j] = 0; m_last_wr[j] = 0;
      lvl_hist[j][0] = 1'b0;
    end
  endfunction

  function automatic void model_write(input int o, input int s, input int m, input int f, input int n);
    if (o < NO) begin
      m_src[o]     = (s < NI + 2) ? s : 0;
      m_mode[o]    = m;
      m_filt[o]    = f;
      m_last_wr[o] = n;
    end
  endfunction

  // Level follows raw only once the last filt+1 raw samples since the latest
  // write all disagree with the current level.
  function automatic logic [NO-1:0] model_edge(input int n);
    logic [NO-1:0] e;
    bit [NI-1:0]   sy;
    bit            r, lb, pb, stable;
    int            t;
    e  = '0;
    sy = (n - SYNC >= 1) ? in_hist[n-SYNC] : '0;
    for (int j = 0; j < NO; j++) begin
      if (m_src[j] >= 2) r = sy[m_src[j]-2];
      else               r = (m_src[j] == 1);
      raw_hist[j][n] = r;
      lb = lvl_hist[j][n-1];
      pb = (n >= 2) ? lvl_hist[j][n-2] : 1'b0;
      stable = 1'b1;
      for (int k = 0; k <= m_filt[j]; k++) begin
        t = n - k;
        if (t <= m_last_wr[j] || raw_hist[j][t] == lb) begin
          stable = 1'b0;
          break;
        end
      end
      lvl_hist[j][n] = stable ? r : lb;
      case (m_mode[j])
        0:       e[j] = lb;
        1:       e[j] = !lb;
        2:       e[j] = lb && !pb;
        default: e[j] = !lb && pb;
      endcase
    end
    return e;
  endfunction

  task automatic write_cfg(input int o, input int s, input int m, input int f);
    @(negedge clk);
    cfg_wr   = 1'b1;
    cfg_out  = OW'(o);
    cfg_src  = SW'(s);
    cfg_mode = 2'(m);
    cfg_filt = FW'(f);
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    model_write(o, s, m, f, 0);
  endtask

  task automatic measure(input int idx, input logic val, input int budget, output int cycles);
    cycles = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (output_lines[idx] === val) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic watch_pair(input int a, input int b, input int cycles,
                            output int ca, output int fa, output int cb, output int fb);
    ca = 0; fa = 0; cb = 0; fb = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      #1;
      if (output_lines[a]) begin ca++; if (fa == 0) fa = k; end
      if (output_lines[b]) begin cb++; if (fb == 0) fb = k; end
    end
  endtask

  task automatic check_cfg_all(input string tag);
    for (int j = 0; j < NO; j++) begin
      rd_sel = OW'(j);
      #1;
      check($sformatf("%s_rd%0d", tag, j), {rd_src, rd_mode, rd_filt},
            {SW'(m_src[j]), 2'(m_mode[j]), FW'(m_filt[j])});
    end
  endtask

  initial begin
    vec_t        tbl[9];
    int          c, ca, fa, cb, fb;
    int          o, s, m, f, sel;
    bit          wr;
    logic [NO-1:0] exp_o;

    tbl[0] = '{6, 1,  0, 2,   6, 1,  0, 2,   10'h068};
    tbl[1] = '{6, 1,  1, 2,   6, 1,  1, 2,   10'h028};
    tbl[2] = '{7, 0,  1, 255, 7, 0,  1, 255, 10'h0A8};
    tbl[3] = '{8, 11, 0, 0,   8, 11, 0, 0,   10'h0A8};
    tbl[4] = '{10, 1, 1, 7,   8, 11, 0, 0,   10'h0A8};
    tbl[5] = '{15, 1, 1, 7,   10, 0, 0, 0,   10'h0A8};
    tbl[6] = '{9, 1,  2, 0,   9, 1,  2, 0,   10'h0A8};
    tbl[7] = '{7, 1,  3, 0,   7, 1,  3, 0,   10'h028};
    tbl[8] = '{8, 12, 1, 0,   8, 0,  1, 0,   10'h128};

    // Reset and idle state
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_lines", output_lines, '0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_lines", output_lines, '0);
    check_cfg_all("reset_cfg");

    // Const1 routed to out3 appears two edges after the write edge
    write_cfg(3, 1, 0, 0);
    @(posedge clk); #1;
    check("t1_out3_e1", output_lines[3], 1'b0);
    @(posedge clk); #1;
    check("t1_out3_e2", output_lines[3], 1'b1);
    rd_sel = 3;
    #1;
    check("t1_rd3", {rd_src, rd_mode, rd_filt}, {4'd1, 2'd0, 8'd0});

    // Unfiltered pin-to-output latency is SYNC+2 in both directions
    write_cfg(0, 2, 0, 0);
    @(negedge clk); input_lines[0] = 1'b1;
    measure(0, 1'b1, 10, c);
    check("t2_rise_latency", c, 4);
    @(negedge clk); input_lines[0] = 1'b0;
    measure(0, 1'b0, 10, c);
    check("t2_fall_latency", c, 4);

    // filt=3 rejects a 3-cycle glitch and passes a held level after 7 cycles
    write_cfg(1, 4, 0, 3);
    @(negedge clk); input_lines[2] = 1'b1;
    repeat (3) @(negedge clk);
    input_lines[2] = 1'b0;
    watch_pair(1, 1, 12, ca, fa, cb, fb);
    check("t3_glitch_rejected", ca, 0);
    @(negedge clk); input_lines[2] = 1'b1;
    measure(1, 1'b1, 12, c);
    check("t3_filtered_rise", c, 7);
    repeat (4) @(negedge clk);
    input_lines[2] = 1'b0;
    measure(1, 1'b0, 12, c);
    check("t3_filtered_fall", c, 7);

    // Rise / fall pulses from the same input, none while held
    write_cfg(2, 3, 2, 0);
    write_cfg(4, 3, 3, 0);
    @(negedge clk); input_lines[1] = 1'b1;
    watch_pair(2, 4, 12, ca, fa, cb, fb);
    check("t4_rise_count", ca, 1);
    check("t4_rise_at", fa, 4);
    check("t4_fall_quiet", cb, 0);
    @(negedge clk); input_lines[1] = 1'b0;
    watch_pair(2, 4, 12, ca, fa, cb, fb);
    check("t4_fall_count", cb, 1);
    check("t4_fall_at", fb, 4);
    check("t4_rise_quiet", ca, 0);

    // Out-of-range writes
    write_cfg(NO, NI + 5, 1, 5);
    repeat (2) @(posedge clk);
    #1;
    check("t5_lines_unchanged", output_lines, 10'h008);
    check_cfg_all("t5_ignored");
    write_cfg(5, NI + 5, 1, 0);
    check("t5_out5_at_e", output_lines[5], 1'b0);
    @(posedge clk); #1;
    check("t5_out5_at_e1", output_lines[5], 1'b1);
    rd_sel = 5;
    #1;
    check("t5_rd5", {rd_src, rd_mode, rd_filt}, {4'd0, 2'd1, 8'd0});

    // Config table: write, settle, then readback and whole output vector
    for (int i = 0; i < 9; i++) begin
      write_cfg(tbl[i].out, tbl[i].src, tbl[i].mode, tbl[i].filt);
      rd_sel = OW'(tbl[i].sel);
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_src", i),   rd_src,   tbl[i].exp_src);
      check($sformatf("tbl%0d_mode", i),  rd_mode,  tbl[i].exp_mode);
      check($sformatf("tbl%0d_filt", i),  rd_filt,  tbl[i].exp_filt);
      check($sformatf("tbl%0d_lines", i), output_lines, tbl[i].exp_lines);
    end

    // Async reset in the middle of a filter count and a rise pulse
    @(negedge clk);
    input_lines[1] = 1'b1;
    input_lines[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_pulse_before_reset", output_lines[2], 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    check("t6_async_clear", output_lines, '0);
    model_clear();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check_cfg_all("t6_defaults");
    ca = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (output_lines != '0) ca++;
    end
    check("t6_stay_low", ca, 0);

    // Randomized run against the reference model
    @(negedge clk);
    rstn = 1'b0;
    input_lines = '0;
    cfg_wr = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_clear();
    for (int n = 1; n <= NCYC; n++) begin
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 5) == 0) input_lines[i] = ~input_lines[i];
      wr  = ($urandom_range(0, 9) == 0);
      o   = $urandom_range(0, NO + 1);
      s   = $urandom_range(0, NI + 3);
      m   = $urandom_range(0, 3);
      f   = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 4);
      sel = $urandom_range(0, NO + 1);
      cfg_wr   = wr;
      cfg_out  = OW'(o);
      cfg_src  = SW'(s);
      cfg_mode = 2'(m);
      cfg_filt = FW'(f);
      rd_sel   = OW'(sel);
      in_hist[n] = input_lines;
      exp_o = model_edge(n);
      if (wr) model_write(o, s, m, f, n);
      @(posedge clk);
      #1;
      check($sformatf("rand_out_c%0d", n), output_lines, exp_o);
      if (sel < NO)
        check($sformatf("rand_rd_c%0d", n), {rd_src, rd_mode, rd_filt},
              {SW'(m_src[sel]), 2'(m_mode[sel]), FW'(m_filt[sel])});
      else
        check($sformatf("rand_rd_c%0d", n), {rd_src, rd_mode, rd_filt}, '0);
      @(negedge clk);
    end
    cfg_wr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
